// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, single-line refill
// over a READ/BUSYWAIT memory handshake, and whole-cache invalidate on FLUSH.
module icache_direct_mapped #(
  parameter int INDEX_BITS = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          READ,
  input  logic [31:0]   PC,
  input  logic          FLUSH,
  output logic [31:0]   INSTRUCTION,
  output logic          BUSYWAIT,
  output logic          MEM_READ,
  output logic [27:0]   MEM_ADDRESS,
  input  logic [127:0]  MEM_READDATA,
  input  logic          MEM_BUSYWAIT
);

  localparam int TAG_W = 28 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [TAG_W-1:0]     tag_d  [LINES];
  logic [127:0]         data_q [LINES];
  logic [127:0]         data_d [LINES];
  logic [27:0]          line_addr_q, line_addr_d;
  logic [127:0]         fill_q, fill_d;
  logic                 issued_q, issued_d;
  logic                 flush_pend_q, flush_pend_d;

  logic [INDEX_BITS-1:0] pc_index_s;
  logic [INDEX_BITS-1:0] fill_index_s;
  logic [TAG_W-1:0]      pc_tag_s;
  logic [TAG_W-1:0]      fill_tag_s;
  logic [1:0]            pc_word_s;
  logic [127:0]          pc_line_s;
  logic                  hit_s;

  assign pc_index_s   = PC[3+INDEX_BITS:4];
  assign pc_tag_s     = PC[31:4+INDEX_BITS];
  assign pc_word_s    = PC[3:2];
  assign fill_index_s = line_addr_q[INDEX_BITS-1:0];
  assign fill_tag_s   = line_addr_q[27:INDEX_BITS];

  assign hit_s       = valid_q[pc_index_s] && (tag_q[pc_index_s] == pc_tag_s);
  assign pc_line_s   = data_q[pc_index_s];
  assign INSTRUCTION = pc_line_s[{pc_word_s, 5'b00000} +: 32];
  assign MEM_ADDRESS = line_addr_q;

  // Next-state, array-update and handshake decode for the refill FSM
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    line_addr_d  = line_addr_q;
    fill_d       = fill_q;
    issued_d     = issued_q;
    flush_pend_d = flush_pend_q;
    BUSYWAIT     = 1'b0;
    MEM_READ     = 1'b0;

    case (state_q)
      IDLE: begin
        issued_d = 1'b0;
        if (READ && !hit_s) begin
          BUSYWAIT    = 1'b1;
          line_addr_d = PC[31:4];
          state_d     = FETCH;
        end else begin
          BUSYWAIT = 1'b0;
          state_d  = IDLE;
        end
        // A deferred flush behaves like a FLUSH pulse in the first idle cycle
        if (FLUSH || flush_pend_q) begin
          valid_d      = {LINES{1'b0}};
          flush_pend_d = 1'b0;
        end else begin
          valid_d      = valid_q;
        end
      end

      FETCH: begin
        MEM_READ = 1'b1;
        BUSYWAIT = 1'b1;
        issued_d = 1'b1;
        if (issued_q && !MEM_BUSYWAIT) begin
          fill_d  = MEM_READDATA;
          state_d = UPDATE;
        end else begin
          state_d = FETCH;
        end
        if (FLUSH) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
      end

      UPDATE: begin
        BUSYWAIT               = 1'b1;
        data_d[fill_index_s]   = fill_q;
        tag_d[fill_index_s]    = fill_tag_s;
        valid_d[fill_index_s]  = 1'b1;
        state_d                = IDLE;
        if (FLUSH) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and valid bits, cleared by synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      valid_q      <= {LINES{1'b0}};
      line_addr_q  <= 28'd0;
      issued_q     <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      line_addr_q  <= line_addr_d;
      issued_q     <= issued_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag/data storage is not reset; held during reset so an aborted refill never lands
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      tag_q  <= tag_d;
      data_q <= data_d;
      fill_q <= fill_d;
    end else begin
      tag_q  <= tag_q;
      data_q <= data_q;
      fill_q <= fill_q;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: directed scenarios plus random traffic checked
// each cycle against a transaction-level cache model and a variable-latency memory.
module tb_icache_direct_mapped;

  logic          clk;
  logic          RESET, READ, FLUSH;
  logic [31:0]   PC;
  logic [31:0]   INSTRUCTION;
  logic          BUSYWAIT, MEM_READ;
  logic [27:0]   MEM_ADDRESS;
  logic [127:0]  MEM_READDATA;
  logic          MEM_BUSYWAIT;

  int n_cmp  = 0;
  int n_fail = 0;

  icache_direct_mapped #(.INDEX_BITS(3)) dut (
    .CLK(clk), .RESET(RESET), .READ(READ), .PC(PC), .FLUSH(FLUSH),
    .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word w of line a, with one fixed instruction at address 0
  function automatic logic [31:0] mem_word(input logic [27:0] a, input logic [1:0] w);
    if (a == 28'd0 && w == 2'd0) return 32'h01E100B3;
    return 32'hC0DE0000 ^ {a, w, 2'b00};
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word(a, w[1:0]);
    return l;
  endfunction

  // Memory responder: ready mem_lat edges after MEM_READ is first seen
  int   mem_lat = 1;
  int   mem_cnt = 0;
  logic mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!MEM_READ) begin
      mem_ready <= 1'b0;
      mem_cnt   <= 0;
    end else if (!mem_ready) begin
      if (mem_cnt + 1 >= mem_lat) mem_ready <= 1'b1;
      mem_cnt <= mem_cnt + 1;
    end
  end
  assign MEM_BUSYWAIT = MEM_READ & ~mem_ready;
  assign MEM_READDATA = mem_ready ? mem_line(MEM_ADDRESS) : ~mem_line(MEM_ADDRESS);

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cache model: contents by line address, refill as a countdown of remaining busy cycles
  bit          m_ok = 1'b0;
  bit          m_valid [8];
  logic [27:0] m_line  [8];
  int          m_rem = 0;
  logic [27:0] m_fill = 28'd0;
  bit          m_pend = 1'b0;

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[pc[6:4]] && (m_line[pc[6:4]] == pc[31:4]);
  endfunction

  always @(negedge clk) begin
    bit exp_bw, exp_mr, hit;
    hit = m_hit(PC);
    if (m_ok) begin
      exp_bw = (m_rem == 0) ? (READ && !hit) : 1'b1;
      exp_mr = (m_rem > 1);
      cmp("busywait", {31'd0, BUSYWAIT}, {31'd0, exp_bw});
      cmp("mem_read", {31'd0, MEM_READ}, {31'd0, exp_mr});
      if (exp_mr) cmp("mem_address", {4'd0, MEM_ADDRESS}, {4'd0, m_fill});
      if (m_rem == 0 && READ && !exp_bw)
        cmp("instruction", INSTRUCTION, mem_word(PC[31:4], PC[3:2]));
    end
    if (RESET) begin
      m_ok = 1'b1; m_rem = 0; m_pend = 1'b0;
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    end else if (m_ok) begin
      if (m_rem == 0) begin
        if (READ && !hit) begin
          m_fill  = PC[31:4];
          mem_lat = $urandom_range(1, 4);
          m_rem   = mem_lat + 2;
        end
        if (FLUSH || m_pend) begin
          m_pend = 1'b0;
          for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        end
      end else begin
        if (FLUSH) m_pend = 1'b1;
        if (m_rem == 1) begin
          m_valid[m_fill[2:0]] = 1'b1;
          m_line[m_fill[2:0]]  = m_fill;
        end
        m_rem--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    @(negedge clk);
    while (BUSYWAIT && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (BUSYWAIT) begin
      n_fail++;
      $display("FAIL %s: BUSYWAIT still 1 after 40 cycles, required 0", nm);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
           ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    RESET = 1'b1; READ = 1'b0; FLUSH = 1'b0; PC = 32'd0;
    step(); step();
    @(negedge clk);
    cmp("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    cmp("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    cmp("reset_mem_address", {4'd0, MEM_ADDRESS}, 32'd0);

    // Cold miss at PC 0
    step(); RESET = 1'b0; READ = 1'b1; PC = 32'h0;
    @(negedge clk);
    cmp("cold_miss_busywait", {31'd0, BUSYWAIT}, 32'd1);
    step();
    @(negedge clk);
    cmp("cold_mem_read", {31'd0, MEM_READ}, 32'd1);
    cmp("cold_mem_address", {4'd0, MEM_ADDRESS}, 32'h0);
    wait_ready("cold_fill");
    cmp("cold_instr", INSTRUCTION, 32'h01E100B3);

    // Sequential hits within the filled line
    for (int i = 1; i < 4; i++) begin
      step(); PC = 32'(i * 4);
      @(negedge clk);
      cmp("seq_hit_busywait", {31'd0, BUSYWAIT}, 32'd0);
      cmp("seq_hit_mem_read", {31'd0, MEM_READ}, 32'd0);
      cmp("seq_hit_instr", INSTRUCTION, 32'hC0DE0000 | 32'(i * 4));
    end

    // Same index, different tag evicts line 0, then 0x0 misses again
    step(); PC = 32'h80;
    @(negedge clk);
    cmp("evict_busywait", {31'd0, BUSYWAIT}, 32'd1);
    step();
    @(negedge clk);
    cmp("evict_mem_address", {4'd0, MEM_ADDRESS}, 32'h8);
    wait_ready("evict_fill");
    cmp("evict_instr", INSTRUCTION, 32'hC0DE0080);
    step(); PC = 32'h0;
    @(negedge clk);
    cmp("reload_busywait", {31'd0, BUSYWAIT}, 32'd1);
    step();
    @(negedge clk);
    cmp("reload_mem_address", {4'd0, MEM_ADDRESS}, 32'h0);
    wait_ready("reload_fill");

    // Fill line 1, flush in idle, then line 1 misses
    step(); PC = 32'h10;
    wait_ready("line1_fill");
    step(); READ = 1'b0; FLUSH = 1'b1;
    step(); FLUSH = 1'b0; READ = 1'b1; PC = 32'h10;
    @(negedge clk);
    cmp("post_flush_busywait", {31'd0, BUSYWAIT}, 32'd1);
    step();
    @(negedge clk);
    cmp("post_flush_mem_read", {31'd0, MEM_READ}, 32'd1);
    cmp("post_flush_mem_address", {4'd0, MEM_ADDRESS}, 32'h1);
    wait_ready("post_flush_fill");

    // Flush while fetching: delivered once, then misses again
    step(); PC = 32'h20;
    step(); FLUSH = 1'b1;
    step(); FLUSH = 1'b0;
    wait_ready("flush_fetch_fill");
    cmp("flush_fetch_instr", INSTRUCTION, 32'hC0DE0020);
    step();
    @(negedge clk);
    cmp("flush_fetch_remiss", {31'd0, BUSYWAIT}, 32'd1);
    wait_ready("flush_fetch_refill");

    // Reset in the middle of a refill
    step(); PC = 32'h30;
    step();
    @(negedge clk);
    cmp("abort_mem_read_before", {31'd0, MEM_READ}, 32'd1);
    step(); RESET = 1'b1;
    step(); RESET = 1'b0;
    @(negedge clk);
    cmp("abort_mem_read_after", {31'd0, MEM_READ}, 32'd0);
    cmp("abort_remiss", {31'd0, BUSYWAIT}, 32'd1);
    wait_ready("abort_refill");

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      RESET = ($urandom_range(0, 299) == 0);
      FLUSH = ($urandom_range(0, 29) == 0);
      READ  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) PC = rand_pc();
    end
    step(); RESET = 1'b0; FLUSH = 1'b0; READ = 1'b0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped read-only instruction cache between the CPU fetch stage (IF) and the 128-bit-line instruction memory.
- IF presents a 32-bit byte PC and gets a 32-bit instruction; misses refill one 16-byte line over the memory's READ/BUSYWAIT handshake.
- Stalls IF via BUSYWAIT until the instruction is valid. Supports whole-cache invalidate (fence.i).

Parameters:
- INDEX_BITS, 3, log2 of line count (default 8 lines x 16 B); tag width = 28 - INDEX_BITS.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  fetch request from IF.
- PC  input  32  fetch byte address; [1:0] ignored; [3:2] word offset; [3+INDEX_BITS:4] index; [31:4+INDEX_BITS] tag.
- FLUSH  input  1  one-cycle pulse; invalidate all lines.
- INSTRUCTION  output  32  selected word; valid only when READ=1 and BUSYWAIT=0.
- BUSYWAIT  output  1  stall to IF.
- MEM_READ  output  1  read request to instruction memory.
- MEM_ADDRESS  output  28  line address = latched PC[31:4].
- MEM_READDATA  input  128  returned line; byte n of line at [8n+7:8n]; word w at [32w+31:32w].
- MEM_BUSYWAIT  input  1  memory busy; rises combinationally with MEM_READ and falls when the line is ready.

Behaviour:
- Storage: per line a valid bit, a tag and 128 data bits. Registered arrays; no reset on data/tag, valid bits only.
- Reset: next posedge gives state=IDLE, all valid=0, pending flush cleared. MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0 with READ=0.
- Hit = valid[index] && tag[index]==PC tag. Combinational; INSTRUCTION = word PC[3:2] of indexed line.
- States IDLE, FETCH, UPDATE.
- IDLE:
  - READ=0: BUSYWAIT=0, no transition.
  - READ=1 and hit: BUSYWAIT=0 in the same cycle (zero-cycle hit latency).
  - READ=1 and miss: BUSYWAIT=1 combinationally. Latch tag/index/PC[31:4]; next state FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS=latched line address, BUSYWAIT=1.
  - An internal "issued" flag is set on the first FETCH edge. Leave FETCH on the first posedge with issued=1 and MEM_BUSYWAIT=0. This prevents sampling MEM_BUSYWAIT before memory has seen MEM_READ.
  - Next state UPDATE, capturing MEM_READDATA on that edge.
- UPDATE (one cycle):
  - MEM_READ=0, BUSYWAIT=1.
  - On the posedge write data, tag and valid=1 into the latched index; next state IDLE.
  - The re-evaluated PC then hits, so total miss penalty = memory latency + 2 cycles.
- PC/READ are required stable while BUSYWAIT=1. If they change anyway, the refill still completes for the latched line and the new PC is evaluated in IDLE.
- READ falling during FETCH/UPDATE: refill completes and the line is installed; BUSYWAIT drops on return to IDLE.
- FLUSH:
  - In IDLE: all valid=0 at the posedge. A READ in the same cycle sees the pre-flush hit result for that cycle only; the next cycle misses.
  - In FETCH/UPDATE: set flush-pending. After the UPDATE write, clear all valid (including the just-filled line) on entry to IDLE.
- RESET mid-refill: abort to IDLE and drop MEM_READ at that edge. The in-flight memory response is ignored and no line is written.
- Index wrap: PC tag change with the same index evicts unconditionally (no replacement choice).
- No X propagation on INSTRUCTION when READ=0 is required; value is don't-care.

Test Plan:
- RESET=1 for 2 cycles -> MEM_READ=0, BUSYWAIT=0. Then READ=1, PC=0x00000000 -> BUSYWAIT=1 same cycle, MEM_READ=1 with MEM_ADDRESS=0x0000000. Memory returns a line with word0=0x01E100B3 -> BUSYWAIT=0 two cycles after MEM_BUSYWAIT falls, INSTRUCTION=0x01E100B3.
- After the fill, PC=0x4, 0x8, 0xC on consecutive cycles -> BUSYWAIT=0 every cycle, MEM_READ never asserted, INSTRUCTION=words 1,2,3 of the line.
- PC=0x00000080 (index 0, tag 1) -> miss, MEM_ADDRESS=0x0000008, line 0 replaced. Then PC=0x0 -> miss again, MEM_ADDRESS=0x0000000.
- FLUSH pulse in IDLE after filling lines 0 and 1. Then PC=0x10 -> miss, MEM_READ=1, MEM_ADDRESS=0x0000001.
- FLUSH during FETCH for PC=0x20 -> refill completes and INSTRUCTION is delivered once. The next access to PC=0x20 misses again.
- RESET asserted for one cycle while in FETCH -> MEM_READ=0 at next edge, state IDLE. Re-requesting the same PC misses (line not installed).
